// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with fetch handshake, redirects
// (branch, jump, call, return) and a circular return-address stack.
// The PC advances by STEP on each accepted fetch, holds on a stall, and
// takes a redirect target one cycle after redir_valid, ignoring fetch_ready.
module pc_sequencer #(
    parameter int AW        = 32,
    parameter int STEP      = 4,
    parameter int RAS_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          redir_valid,
    input  logic [1:0]    redir_mode,
    input  logic [AW-1:0] redir_val,
    output logic [AW-1:0] fetch_addr,
    output logic          fetch_valid,
    input  logic          fetch_ready,
    output logic          ras_overflow,
    output logic          ras_underflow
);

    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [AW-1:0] STEP_V     = AW'(STEP);
    // Clears the low log2(STEP) bits so every target is STEP-aligned.
    localparam logic [AW-1:0] ALIGN_MASK = ~(STEP_V - AW'(1));
    localparam logic [PW:0]   DEPTH_V    = (PW+1)'(RAS_DEPTH);

    localparam logic [1:0] MODE_BRANCH = 2'b00;
    localparam logic [1:0] MODE_JUMP   = 2'b01;
    localparam logic [1:0] MODE_CALL   = 2'b10;
    localparam logic [1:0] MODE_RETURN = 2'b11;

    logic [AW-1:0] r_addr;
    logic          r_valid;
    logic          r_ovf;
    logic          r_unf;
    logic [AW-1:0] r_ras [RAS_DEPTH];
    logic [PW-1:0] r_top;   // slot the next push writes
    logic [PW:0]   r_cnt;   // entries held, saturates at RAS_DEPTH

    logic [AW-1:0] w_seq;
    logic [PW-1:0] w_top_idx;
    logic          w_ras_empty;
    logic          w_ras_full;
    logic          w_redir;
    logic          w_push;
    logic          w_pop;
    logic          w_unf_set;
    logic [AW-1:0] w_raw_target;
    logic [AW-1:0] w_next_addr;

    assign w_seq       = r_addr + STEP_V;
    assign w_top_idx   = r_top - PW'(1);
    assign w_ras_empty = (r_cnt == '0);
    assign w_ras_full  = (r_cnt == DEPTH_V);
    // The cycle straight after reset only raises fetch_valid; redirects wait.
    assign w_redir     = r_valid & redir_valid;

    // Decode the redirect kind into a raw target and RAS push/pop requests.
    always_comb begin
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_unf_set    = 1'b0;
        w_raw_target = w_seq;
        case (redir_mode)
            MODE_BRANCH: w_raw_target = r_addr + redir_val;
            MODE_JUMP:   w_raw_target = redir_val;
            MODE_CALL: begin
                w_raw_target = r_addr + redir_val;
                w_push       = w_redir;
            end
            MODE_RETURN: begin
                if (w_ras_empty) begin
                    w_raw_target = w_seq;
                    w_unf_set    = w_redir;
                end else begin
                    w_raw_target = r_ras[w_top_idx];
                    w_pop        = w_redir;
                end
            end
            default: w_raw_target = w_seq;
        endcase
    end

    // Select the next fetch address: redirect beats advance beats stall.
    always_comb begin
        w_next_addr = r_addr;
        if (w_redir) begin
            w_next_addr = w_raw_target & ALIGN_MASK;
        end else if (r_valid && fetch_ready) begin
            w_next_addr = w_seq;
        end
    end

    // PC, valid, stack pointer/occupancy and sticky flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr  <= '0;
            r_valid <= 1'b0;
            r_top   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_valid <= 1'b1;
            r_addr  <= w_next_addr;
            if (w_push) begin
                r_top <= r_top + PW'(1);
                if (w_ras_full) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + (PW+1)'(1);
                end
            end
            if (w_pop) begin
                r_top <= w_top_idx;
                r_cnt <= r_cnt - (PW+1)'(1);
            end
            if (w_unf_set) begin
                r_unf <= 1'b1;
            end
        end
    end

    // Return-address storage; a push onto a full stack overwrites the oldest slot.
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_ras[r_top] <= w_seq;
        end
    end

    assign fetch_addr    = r_addr;
    assign fetch_valid   = r_valid;
    assign ras_overflow  = r_ovf;
    assign ras_underflow = r_unf;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scenarios followed by random traffic, all checked
// against a queue-based behavioural model of the PC and return-address stack.
module tb_pc_sequencer;

    localparam int AW    = 32;
    localparam int STEP  = 4;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          redir_valid;
    logic [1:0]    redir_mode;
    logic [AW-1:0] redir_val;
    logic [AW-1:0] fetch_addr;
    logic          fetch_valid;
    logic          fetch_ready;
    logic          ras_overflow;
    logic          ras_underflow;

    int n_checks = 0;
    int n_fail   = 0;
    int n_txn    = 0;

    // Reference model state.
    logic [31:0] m_addr;
    logic        m_valid;
    logic        m_ovf;
    logic        m_unf;
    logic [31:0] m_ras[$];

    pc_sequencer #(.AW(AW), .STEP(STEP), .RAS_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .redir_valid  (redir_valid),
        .redir_mode   (redir_mode),
        .redir_val    (redir_val),
        .fetch_addr   (fetch_addr),
        .fetch_valid  (fetch_valid),
        .fetch_ready  (fetch_ready),
        .ras_overflow (ras_overflow),
        .ras_underflow(ras_underflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply one edge of behaviour to the model, straight from the rules.
    task automatic model_edge(input bit rst, input bit rv, input logic [1:0] md,
                              input logic [31:0] val, input bit rdy);
        logic [31:0] t;
        if (rst) begin
            m_addr  = 0;
            m_valid = 0;
            m_ovf   = 0;
            m_unf   = 0;
            m_ras.delete();
        end else if (!m_valid) begin
            m_valid = 1;
        end else if (rv) begin
            t = m_addr + STEP;
            if (md == 2'd0) begin
                t = m_addr + val;
            end else if (md == 2'd1) begin
                t = val;
            end else if (md == 2'd2) begin
                t = m_addr + val;
                m_ras.push_back(m_addr + STEP);
                if (m_ras.size() > DEPTH) begin
                    void'(m_ras.pop_front());
                    m_ovf = 1;
                end
            end else begin
                if (m_ras.size() > 0) t = m_ras.pop_back();
                else                  m_unf = 1;
            end
            m_addr = t & ~(STEP - 1);
        end else if (rdy) begin
            m_addr = m_addr + STEP;
        end
    endtask

    // One transaction: drive, clock, update model, compare all outputs.
    task automatic cycle(input bit rst, input bit rv, input logic [1:0] md,
                         input logic [31:0] val, input bit rdy);
        reset       = rst;
        redir_valid = rv;
        redir_mode  = md;
        redir_val   = val;
        fetch_ready = rdy;
        @(posedge clk);
        model_edge(rst, rv, md, val, rdy);
        #1;
        n_txn++;
        $display("txn %0d rst=%0b rv=%0b md=%0d val=%h rdy=%0b -> addr=%h v=%0b ovf=%0b unf=%0b",
                 n_txn, rst, rv, md, val, rdy, fetch_addr, fetch_valid, ras_overflow, ras_underflow);
        check_eq("fetch_addr",    64'(fetch_addr),    64'(m_addr));
        check_eq("fetch_valid",   64'(fetch_valid),   64'(m_valid));
        check_eq("ras_overflow",  64'(ras_overflow),  64'(m_ovf));
        check_eq("ras_underflow", 64'(ras_underflow), 64'(m_unf));
    endtask

    task automatic do_reset();
        cycle(1, 0, 0, 0, 0);
        cycle(1, 1, 2, 32'h10, 1);
        check_eq("reset_addr",  64'(fetch_addr),  64'h0);
        check_eq("reset_valid", 64'(fetch_valid), 64'h0);
        cycle(0, 1, 1, 32'h500, 1);   // redirect ignored on the first edge
        check_eq("release_addr",  64'(fetch_addr),  64'h0);
        check_eq("release_valid", 64'(fetch_valid), 64'h1);
    endtask

    initial begin
        reset = 1; redir_valid = 0; redir_mode = 0; redir_val = 0; fetch_ready = 0;
        m_addr = 0; m_valid = 0; m_ovf = 0; m_unf = 0;

        // Sequential advance and stall.
        do_reset();
        cycle(0, 0, 0, 0, 1); cycle(0, 0, 0, 0, 1); cycle(0, 0, 0, 0, 1);
        check_eq("seq_12", 64'(fetch_addr), 64'hC);
        cycle(0, 0, 0, 0, 0); cycle(0, 0, 0, 0, 0);
        check_eq("stall_12", 64'(fetch_addr), 64'hC);
        cycle(0, 0, 0, 0, 1);
        check_eq("seq_16", 64'(fetch_addr), 64'h10);

        // Branch backwards while stalled.
        cycle(0, 1, 1, 32'h40, 1);
        cycle(0, 1, 0, 32'hFFFF_FFF8, 0);
        check_eq("branch_38", 64'(fetch_addr), 64'h38);

        // Jump target alignment.
        cycle(0, 1, 1, 32'h1003, 1);
        check_eq("jump_align", 64'(fetch_addr), 64'h1000);

        // Nested call/return, then return on an empty stack.
        cycle(0, 1, 1, 32'h100, 1);
        cycle(0, 1, 2, 32'h200, 0);
        check_eq("call_300", 64'(fetch_addr), 64'h300);
        cycle(0, 1, 2, 32'h10, 1);
        check_eq("call_310", 64'(fetch_addr), 64'h310);
        cycle(0, 1, 3, 32'hDEAD, 1);
        check_eq("ret_304", 64'(fetch_addr), 64'h304);
        cycle(0, 1, 3, 0, 0);
        check_eq("ret_104", 64'(fetch_addr), 64'h104);
        cycle(0, 1, 3, 0, 1);
        check_eq("ret_empty_addr", 64'(fetch_addr), 64'h108);
        check_eq("ret_empty_unf",  64'(ras_underflow), 64'h1);

        // Overflow: five calls into a four-entry stack.
        do_reset();
        for (int i = 0; i < 5; i++) cycle(0, 1, 2, 32'h10, 1);
        check_eq("ovf_flag", 64'(ras_overflow), 64'h1);
        cycle(0, 1, 3, 0, 1); check_eq("ovf_ret0", 64'(fetch_addr), 64'h44);
        cycle(0, 1, 3, 0, 1); check_eq("ovf_ret1", 64'(fetch_addr), 64'h34);
        cycle(0, 1, 3, 0, 1); check_eq("ovf_ret2", 64'(fetch_addr), 64'h24);
        cycle(0, 1, 3, 0, 1); check_eq("ovf_ret3", 64'(fetch_addr), 64'h14);
        check_eq("ovf_no_unf", 64'(ras_underflow), 64'h0);
        cycle(0, 1, 3, 0, 1);
        check_eq("ovf_ret4_unf", 64'(ras_underflow), 64'h1);

        // Address wrap, then reset in the middle of a call.
        cycle(0, 1, 1, 32'hFFFF_FFFC, 1);
        cycle(0, 0, 0, 0, 1);
        check_eq("wrap_0", 64'(fetch_addr), 64'h0);
        cycle(0, 1, 2, 32'h80, 1);
        cycle(1, 1, 2, 32'h80, 1);
        check_eq("rst_call_addr",  64'(fetch_addr),    64'h0);
        check_eq("rst_call_valid", 64'(fetch_valid),   64'h0);
        check_eq("rst_call_ovf",   64'(ras_overflow),  64'h0);
        check_eq("rst_call_unf",   64'(ras_underflow), 64'h0);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 1, 3, 0, 1);
        check_eq("rst_ras_empty", 64'(ras_underflow), 64'h1);
        check_eq("rst_ras_addr",  64'(fetch_addr),    64'h4);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            bit          r_rst;
            bit          r_rv;
            logic [1:0]  r_md;
            logic [31:0] r_val;
            r_rst = ($urandom_range(0, 79) == 0);
            r_rv  = ($urandom_range(0, 2) == 0);
            r_md  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) r_val = $urandom;
            else r_val = 32'($signed($urandom_range(0, 1023)) - 512);
            cycle(r_rst, r_rv, r_md, r_val, bit'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
